// File: rtl/phy_lane_serdes_pkg.sv
// Shared symbol constants, receiver state encoding and word-slot geometry.
// Geometry helpers turn DATA_W/LANES into symbols per lane and cycles per word slot.
package phy_lane_serdes_pkg;

  localparam logic [8:0] SYM_COM = 9'h1BC;
  localparam logic [8:0] SYM_IDL = 9'h17C;

  typedef enum logic [1:0] {
    RX_HUNT   = 2'd0,
    RX_CHECK  = 2'd1,
    RX_LOCKED = 2'd2
  } rx_state_t;

  function automatic int calc_bpl(input int data_w, input int lanes);
    return data_w / (8 * lanes);
  endfunction

  function automatic int calc_slot_cycles(input int data_w, input int lanes);
    return 9 * calc_bpl(data_w, lanes);
  endfunction

endpackage

// File: rtl/phy_lane_rx_align.sv
// One receive lane: input capture flop, 9-bit symbol window and COM detector.
// Latency: a line bit reaches the window two edges after it is driven; no backpressure.
module phy_lane_rx_align
  import phy_lane_serdes_pkg::*;
(
  input  logic       clk_32f,
  input  logic       reset,
  input  logic       ser_bit,
  output logic [8:0] win,
  output logic       com_hit
);

  logic       bit_q, bit_d;
  logic [8:0] win_q, win_d;

  always_comb begin
    bit_d = ser_bit;
    win_d = {win_q[7:0], bit_q};
  end

  always_ff @(posedge clk_32f or negedge reset) begin
    if (!reset) begin
      bit_q <= 1'b0;
      win_q <= '0;
    end else begin
      bit_q <= bit_d;
      win_q <= win_d;
    end
  end

  assign win     = win_q;
  assign com_hit = (win_q == SYM_COM);

endmodule

// File: rtl/phy_lane_serdes.sv
// Lane-striped 9-bit-symbol serdes with training, COM word alignment and loopback.
// Latency S+3 cycles from word_tick to valid_out; no backpressure, data offered while ready_out=0 is dropped.
module phy_lane_serdes
  import phy_lane_serdes_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int LANES       = 1,
  parameter int TRAIN_WORDS = 4,
  parameter int LOCK_CNT    = 3,
  parameter int LOSS_CNT    = 2
) (
  input  logic              clk_32f,
  input  logic              reset,
  input  logic [DATA_W-1:0] data_in,
  input  logic              valid_in,
  output logic              ready_out,
  output logic              word_tick,
  input  logic              loopback_en,
  output logic [LANES-1:0]  ser_out,
  input  logic [LANES-1:0]  ser_in,
  output logic [DATA_W-1:0] data_out,
  output logic              valid_out,
  output logic              locked,
  output logic [7:0]        err_count
);

  localparam int BPL = calc_bpl(DATA_W, LANES);
  localparam int S   = calc_slot_cycles(DATA_W, LANES);
  localparam int PW  = $clog2(S);
  localparam int SW  = (BPL > 1) ? $clog2(BPL) : 1;
  localparam int TW  = $clog2(TRAIN_WORDS + 1);
  localparam int MW  = $clog2(LOCK_CNT + 1);
  localparam int EW  = $clog2(LOSS_CNT + 1);

  logic [PW-1:0]                  phase_q, phase_d;
  logic                           word_tick_q, word_tick_d;
  logic [TW-1:0]                  train_q, train_d;
  logic                           ready_q, ready_d;
  logic [LANES-1:0][S-1:0]        tx_sr_q, tx_sr_d;
  logic                           send_data;

  logic [LANES-1:0]               rx_src;
  logic [LANES-1:0][8:0]          rx_win;
  logic [LANES-1:0]               com_hit;
  logic [LANES-1:0][BPL-1:0][8:0] rx_buf_q, rx_buf_d;
  rx_state_t                      state_q, state_d;
  logic [3:0]                     bit_cnt_q, bit_cnt_d;
  logic [SW-1:0]                  slot_q, slot_d;
  logic [MW-1:0]                  match_q, match_d;
  logic [EW-1:0]                  loss_q, loss_d;
  logic [7:0]                     err_q, err_d;
  logic [DATA_W-1:0]              dout_q, dout_d;
  logic                           vout_q, vout_d;
  logic                           locked_q, locked_d;

  logic                           sym_done, last_slot, all_com, all_data, idle_ok;
  logic [DATA_W-1:0]              word_dat;

  assign send_data = ready_q & valid_in;

  // Shift registers hold a whole word slot; slot 0 sits in the MSBs so it goes out first.
  always_comb begin
    phase_d     = (phase_q == PW'(S - 1)) ? '0 : phase_q + 1'b1;
    word_tick_d = (phase_d == '0);
    train_d     = train_q;
    ready_d     = ready_q;
    for (int l = 0; l < LANES; l++) tx_sr_d[l] = {tx_sr_q[l][S-2:0], 1'b0};
    if (word_tick_q) begin
      for (int l = 0; l < LANES; l++) begin
        for (int s = 0; s < BPL; s++) begin
          if (send_data)   tx_sr_d[l][S-1-9*s -: 9] = {1'b0, data_in[8*(s*LANES+l) +: 8]};
          else if (s == 0) tx_sr_d[l][S-1-9*s -: 9] = SYM_COM;
          else             tx_sr_d[l][S-1-9*s -: 9] = SYM_IDL;
        end
      end
      if (!ready_q) begin
        train_d = train_q + 1'b1;
        if (train_q == TW'(TRAIN_WORDS - 1)) ready_d = 1'b1;
      end
    end
  end

  assign rx_src = loopback_en ? ser_out : ser_in;

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    assign ser_out[g] = tx_sr_q[g][S-1];
    phy_lane_rx_align u_align (
      .clk_32f (clk_32f),
      .reset   (reset),
      .ser_bit (rx_src[g]),
      .win     (rx_win[g]),
      .com_hit (com_hit[g])
    );
  end

  assign all_com   = &com_hit;
  assign sym_done  = (bit_cnt_q == 4'd8);
  assign last_slot = (slot_q == SW'(BPL - 1));

  // The last slot of a word is still in the window when the word is judged.
  always_comb begin
    all_data = 1'b1;
    idle_ok  = 1'b1;
    word_dat = '0;
    for (int l = 0; l < LANES; l++) begin
      for (int s = 0; s < BPL; s++) begin
        logic [8:0] sym;
        sym = (s == BPL - 1) ? rx_win[l] : rx_buf_q[l][s];
        all_data = all_data & ~sym[8];
        idle_ok  = idle_ok & (sym == ((s == 0) ? SYM_COM : SYM_IDL));
        word_dat[8*(s*LANES+l) +: 8] = sym[7:0];
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = sym_done ? 4'd0 : bit_cnt_q + 4'd1;
    slot_d    = slot_q;
    rx_buf_d  = rx_buf_q;
    match_d   = match_q;
    loss_d    = loss_q;
    err_d     = err_q;
    dout_d    = dout_q;
    vout_d    = 1'b0;
    if (sym_done) begin
      for (int l = 0; l < LANES; l++) rx_buf_d[l][slot_q] = rx_win[l];
      slot_d = last_slot ? '0 : slot_q + 1'b1;
    end
    case (state_q)
      RX_HUNT: begin
        if (all_com) begin
          state_d   = (LOCK_CNT <= 1) ? RX_LOCKED : RX_CHECK;
          match_d   = MW'(1);
          loss_d    = '0;
          bit_cnt_d = 4'd0;
          slot_d    = (BPL > 1) ? SW'(1) : '0;
          for (int l = 0; l < LANES; l++) rx_buf_d[l][0] = rx_win[l];
        end
      end
      RX_CHECK: begin
        if (sym_done && slot_q == '0) begin
          if (!all_com) begin
            state_d = RX_HUNT;
          end else begin
            match_d = match_q + 1'b1;
            if ((match_q + 1'b1) == MW'(LOCK_CNT)) state_d = RX_LOCKED;
          end
        end
      end
      RX_LOCKED: begin
        if (sym_done && last_slot) begin
          if (all_data) begin
            dout_d = word_dat;
            vout_d = 1'b1;
            loss_d = '0;
          end else if (idle_ok) begin
            loss_d = '0;
          end else begin
            if (err_q != 8'hFF) err_d = err_q + 8'd1;
            if (loss_q == EW'(LOSS_CNT - 1)) begin
              state_d = RX_HUNT;
              loss_d  = '0;
            end else begin
              loss_d = loss_q + 1'b1;
            end
          end
        end
      end
      default: state_d = RX_HUNT;
    endcase
    locked_d = (state_d == RX_LOCKED);
  end

  always_ff @(posedge clk_32f or negedge reset) begin
    if (!reset) begin
      phase_q     <= '0;
      word_tick_q <= 1'b0;
      train_q     <= '0;
      ready_q     <= 1'b0;
      tx_sr_q     <= '0;
      rx_buf_q    <= '0;
      state_q     <= RX_HUNT;
      bit_cnt_q   <= '0;
      slot_q      <= '0;
      match_q     <= '0;
      loss_q      <= '0;
      err_q       <= '0;
      dout_q      <= '0;
      vout_q      <= 1'b0;
      locked_q    <= 1'b0;
    end else begin
      phase_q     <= phase_d;
      word_tick_q <= word_tick_d;
      train_q     <= train_d;
      ready_q     <= ready_d;
      tx_sr_q     <= tx_sr_d;
      rx_buf_q    <= rx_buf_d;
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      slot_q      <= slot_d;
      match_q     <= match_d;
      loss_q      <= loss_d;
      err_q       <= err_d;
      dout_q      <= dout_d;
      vout_q      <= vout_d;
      locked_q    <= locked_d;
    end
  end

  assign word_tick = word_tick_q;
  assign ready_out = ready_q;
  assign data_out  = dout_q;
  assign valid_out = vout_q;
  assign locked    = locked_q;
  assign err_count = err_q;

endmodule

// File: tb/tb_phy_lane_serdes.sv
// Directed bench: a 1-lane instance covers training, data, errors and reset; a 2-lane instance covers striping.
module tb_phy_lane_serdes;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  int          cyc = 0;
  int          n_tests = 0;
  int          n_fail = 0;

  logic [31:0] d1_data_in = '0;
  logic        d1_valid_in = 1'b0;
  logic        d1_ready, d1_tick, d1_vout, d1_locked;
  logic        d1_lb = 1'b1;
  logic [0:0]  d1_ser_out, d1_ser_in;
  logic [0:0]  d1_flip = 1'b0;
  logic [31:0] d1_data_out;
  logic [7:0]  d1_err;

  logic [31:0] d2_data_in = '0;
  logic        d2_valid_in = 1'b0;
  logic        d2_ready, d2_tick, d2_vout, d2_locked;
  logic [1:0]  d2_ser_out;
  logic [1:0]  d2_ser_in = 2'b00;
  logic [31:0] d2_data_out;
  logic [7:0]  d2_err;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign d1_ser_in = d1_ser_out ^ d1_flip;

  phy_lane_serdes #(.DATA_W(32), .LANES(1)) dut1 (
    .clk_32f(clk), .reset(rst_n), .data_in(d1_data_in), .valid_in(d1_valid_in),
    .ready_out(d1_ready), .word_tick(d1_tick), .loopback_en(d1_lb), .ser_out(d1_ser_out),
    .ser_in(d1_ser_in), .data_out(d1_data_out), .valid_out(d1_vout), .locked(d1_locked),
    .err_count(d1_err)
  );

  phy_lane_serdes #(.DATA_W(32), .LANES(2)) dut2 (
    .clk_32f(clk), .reset(rst_n), .data_in(d2_data_in), .valid_in(d2_valid_in),
    .ready_out(d2_ready), .word_tick(d2_tick), .loopback_en(1'b1), .ser_out(d2_ser_out),
    .ser_in(d2_ser_in), .data_out(d2_data_out), .valid_out(d2_vout), .locked(d2_locked),
    .err_count(d2_err)
  );

  task automatic wait_d1_tick(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (d1_tick) begin ok = 1'b1; break; end
    end
  endtask

  task automatic do_reset(output bit ok);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (d1_ready) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    int ticks = 0, vp = 0;
    bit seen = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_tests++; if ({d1_ready, d1_tick, d1_vout, d1_locked} !== 4'b0000) begin n_fail++; $display("FAIL reset_ctrl got=%b want=0000", {d1_ready, d1_tick, d1_vout, d1_locked}); end
    n_tests++; if (d1_err !== 8'd0) begin n_fail++; $display("FAIL reset_err got=%0d want=0", d1_err); end
    n_tests++; if (d1_data_out !== 32'd0) begin n_fail++; $display("FAIL reset_data got=%h want=0", d1_data_out); end
    n_tests++; if (d1_ser_out !== 1'b0) begin n_fail++; $display("FAIL reset_ser got=%b want=0", d1_ser_out); end
    rst_n = 1'b1;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (d1_vout) vp++;
      if (d1_tick) ticks++;
      if (d1_ready) begin seen = 1'b1; break; end
    end
    n_tests++; if (!seen) begin n_fail++; $display("FAIL train_timeout ready_out never rose"); end
    n_tests++; if (ticks != 4) begin n_fail++; $display("FAIL train_ticks got=%0d want=4", ticks); end
    n_tests++; if (vp != 0) begin n_fail++; $display("FAIL train_valid got=%0d pulses want=0", vp); end
    n_tests++; if (d1_locked !== 1'b1) begin n_fail++; $display("FAIL train_lock got=%b want=1", d1_locked); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] w[3];
    int tick_cyc[3];
    int sent = 0, got = 0, last_vo = 0;
    w[0] = 32'hDEADBEEF; w[1] = 32'h000000BC; w[2] = 32'hBCBCBCBC;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (d1_tick) begin
        if (sent < 3) begin
          d1_data_in = w[sent]; d1_valid_in = 1'b1; tick_cyc[sent] = cyc; sent++;
        end else begin
          d1_valid_in = 1'b0;
        end
      end
      if (d1_vout) begin
        n_tests++;
        if (got >= 3) begin
          n_fail++; $display("FAIL b2b_extra pulse %0d want none", got);
        end else begin
          if (d1_data_out !== w[got]) begin n_fail++; $display("FAIL b2b_data%0d got=%h want=%h", got, d1_data_out, w[got]); end
          n_tests++; if (cyc - tick_cyc[got] != 39) begin n_fail++; $display("FAIL b2b_lat%0d got=%0d want=39", got, cyc - tick_cyc[got]); end
          if (got > 0) begin
            n_tests++; if (cyc - last_vo != 36) begin n_fail++; $display("FAIL b2b_gap%0d got=%0d want=36", got, cyc - last_vo); end
          end
        end
        last_vo = cyc;
        got++;
      end
    end
    d1_valid_in = 1'b0;
    n_tests++; if (got != 3) begin n_fail++; $display("FAIL b2b_count got=%0d want=3", got); end
    n_tests++; if (d1_err !== 8'd0) begin n_fail++; $display("FAIL b2b_err got=%0d want=0", d1_err); end
  endtask

  task automatic test_lanes2();
    bit ok = 1'b0;
    int c0 = 0;
    logic [8:0] s0 = '0, s1 = '0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (d2_tick && d2_ready && d2_locked) begin ok = 1'b1; break; end
    end
    n_tests++; if (!ok) begin n_fail++; $display("FAIL l2_ready timeout ready/locked not seen"); end
    d2_data_in = 32'h11223344; d2_valid_in = 1'b1; c0 = cyc;
    for (int j = 0; j < 9; j++) begin
      @(negedge clk);
      d2_valid_in = 1'b0;
      s0 = {s0[7:0], d2_ser_out[0]};
      s1 = {s1[7:0], d2_ser_out[1]};
    end
    n_tests++; if (s0 !== 9'h044) begin n_fail++; $display("FAIL l2_lane0 got=%h want=044", s0); end
    n_tests++; if (s1 !== 9'h033) begin n_fail++; $display("FAIL l2_lane1 got=%h want=033", s1); end
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (d2_vout) begin ok = 1'b1; break; end
    end
    n_tests++; if (!ok) begin n_fail++; $display("FAIL l2_valid timeout"); end
    n_tests++; if (cyc - c0 != 21) begin n_fail++; $display("FAIL l2_lat got=%0d want=21", cyc - c0); end
    n_tests++; if (d2_data_out !== 32'h11223344) begin n_fail++; $display("FAIL l2_data got=%h want=11223344", d2_data_out); end
  endtask

  task automatic test_err_burst();
    bit ok;
    bit unlocked = 1'b0, relocked = 1'b0;
    int ticks = 0;
    logic [7:0] err_at_drop = '0;
    do_reset(ok);
    n_tests++; if (!ok) begin n_fail++; $display("FAIL eb_train timeout"); end
    d1_lb = 1'b0;
    for (int w = 0; w < 2; w++) begin
      wait_d1_tick(ok);
      n_tests++; if (!ok) begin n_fail++; $display("FAIL eb_tick%0d timeout", w); end
      repeat (6) @(negedge clk);
      d1_flip = 1'b1;
      @(negedge clk);
      d1_flip = 1'b0;
    end
    n_tests++; if ({d1_locked, d1_err} !== {1'b1, 8'd1}) begin n_fail++; $display("FAIL eb_first got locked=%b err=%0d want locked=1 err=1", d1_locked, d1_err); end
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (d1_tick) ticks++;
      if (!d1_locked && !unlocked) begin unlocked = 1'b1; err_at_drop = d1_err; end
      if (unlocked && d1_locked) begin relocked = 1'b1; break; end
    end
    n_tests++; if (!unlocked) begin n_fail++; $display("FAIL eb_drop locked never fell"); end
    n_tests++; if (err_at_drop !== 8'd2) begin n_fail++; $display("FAIL eb_err got=%0d want=2", err_at_drop); end
    n_tests++; if (!relocked) begin n_fail++; $display("FAIL eb_relock timeout"); end
    n_tests++; if (ticks != 3) begin n_fail++; $display("FAIL eb_relock_words got=%0d want=3", ticks); end
    d1_lb = 1'b1;
  endtask

  task automatic test_illegal_k();
    bit ok;
    logic [8:0] mask = 9'h0BC;
    do_reset(ok);
    n_tests++; if (!ok) begin n_fail++; $display("FAIL ik_train timeout"); end
    d1_lb = 1'b0;
    wait_d1_tick(ok);
    n_tests++; if (!ok) begin n_fail++; $display("FAIL ik_tick timeout"); end
    for (int j = 0; j < 9; j++) begin
      @(negedge clk);
      d1_flip = mask[8-j];
    end
    @(negedge clk);
    d1_flip = 1'b0;
    wait_d1_tick(ok);
    d1_data_in = 32'h12BC34BC; d1_valid_in = 1'b1;
    @(negedge clk);
    d1_valid_in = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (d1_vout) begin ok = 1'b1; break; end
    end
    n_tests++; if (!ok) begin n_fail++; $display("FAIL ik_valid timeout"); end
    n_tests++; if (d1_data_out !== 32'h12BC34BC) begin n_fail++; $display("FAIL ik_data got=%h want=12bc34bc", d1_data_out); end
    n_tests++; if (d1_err !== 8'd1) begin n_fail++; $display("FAIL ik_err got=%0d want=1", d1_err); end
    n_tests++; if (d1_locked !== 1'b1) begin n_fail++; $display("FAIL ik_lock got=%b want=1", d1_locked); end
    d1_lb = 1'b1;
  endtask

  task automatic test_reset_mid();
    bit ok, seen = 1'b0;
    int ticks = 0, vp = 0;
    wait_d1_tick(ok);
    n_tests++; if (!ok) begin n_fail++; $display("FAIL rm_tick timeout"); end
    d1_data_in = 32'h5A5AA5A5; d1_valid_in = 1'b1;
    @(negedge clk);
    d1_valid_in = 1'b0;
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_tests++; if ({d1_ready, d1_tick, d1_vout, d1_locked} !== 4'b0000) begin n_fail++; $display("FAIL rm_ctrl got=%b want=0000", {d1_ready, d1_tick, d1_vout, d1_locked}); end
    n_tests++; if ({d1_err, d1_ser_out} !== 9'd0) begin n_fail++; $display("FAIL rm_err_ser got=%h want=0", {d1_err, d1_ser_out}); end
    n_tests++; if (d1_data_out !== 32'd0) begin n_fail++; $display("FAIL rm_data got=%h want=0", d1_data_out); end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (d1_vout) vp++;
      if (d1_tick) ticks++;
      if (d1_ready) begin seen = 1'b1; break; end
    end
    n_tests++; if (!seen) begin n_fail++; $display("FAIL rm_train timeout"); end
    n_tests++; if (ticks != 4) begin n_fail++; $display("FAIL rm_ticks got=%0d want=4", ticks); end
    n_tests++; if (vp != 0) begin n_fail++; $display("FAIL rm_valid got=%0d pulses want=0", vp); end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_lanes2();
    test_err_burst();
    test_illegal_k();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
